// File: rtl/cache_access_arbiter.sv
`timescale 1ns/1ps
// cache_access_arbiter
// Shares the single cache_controller request interface between the CPU
// request port and the interconnect snoop port. Runs one transaction at a
// time: accept (IDLE) -> issue strobe (ISSUE) -> wait for completion (WAIT)
// -> respond (DONE). Snoops normally win arbitration, but a CPU request that
// has lost STARVE_LIMIT times in a row is forced through. A WAIT that lasts
// TIMEOUT cycles without completion is aborted with a timeout_err pulse.
//
// Handshake: a requester raises *_req_valid with a stable *_req_op and holds
// both until it sees *_req_ready high in the same cycle; that cycle is the
// transfer. *_req_ready is only ever high in IDLE, for at most one port.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cpu_req_valid/op/ready        CPU request port (op: 00 read, 01 write)
//   cpu_resp_valid                one-cycle pulse when a CPU op finishes
//   snp_req_valid/op/ready        snoop port (op: 00 read-shared, 01 inval)
//   snp_resp_valid                one-cycle pulse when a snoop op finishes
//   ctrl_cpu_request              op to controller, 11 when idle
//   ctrl_snoop_sel                current op came from the snoop port
//   ctrl_start                    one-cycle issue strobe
//   cache_ready, cache_complete   status from cache_controller
//   busy                          not in IDLE
//   timeout_err                   one-cycle pulse on WAIT timeout
module cache_access_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req_valid,
  input  logic [1:0] cpu_req_op,
  output logic       cpu_req_ready,
  output logic       cpu_resp_valid,
  input  logic       snp_req_valid,
  input  logic [1:0] snp_req_op,
  output logic       snp_req_ready,
  output logic       snp_resp_valid,
  output logic [1:0] ctrl_cpu_request,
  output logic       ctrl_snoop_sel,
  output logic       ctrl_start,
  input  logic       cache_ready,
  input  logic       cache_complete,
  output logic       busy,
  output logic       timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          src_q;      // 1 = latched op came from the snoop port
  logic          op_q;       // op bit 0; bit 1 of the request op is ignored
  logic [SW-1:0] streak_q;   // consecutive snoop wins while CPU was waiting
  logic [TW-1:0] tcnt_q;     // cycles spent in WAIT

  logic cpu_win, snp_win, grant, cmpl, tmo, in_flight;

  // Only bit 0 of each request op is meaningful.
  logic unused_op_bits;
  assign unused_op_bits = ^{cpu_req_op[1], snp_req_op[1]};

  always_comb begin
    cpu_win   = cpu_req_valid && (!snp_req_valid || streak_q == STREAK_MAX);
    snp_win   = snp_req_valid && !cpu_win;
    grant     = (state_q == S_IDLE) && !reset && (cpu_win || snp_win);
    cmpl      = cache_complete && cache_ready;
    // Completion on the last allowed WAIT cycle still wins over the timeout.
    tmo       = (state_q == S_WAIT) && !cmpl && (tcnt_q == TCNT_LAST);
    in_flight = (state_q == S_ISSUE) || (state_q == S_WAIT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  begin
        if (cmpl)     state_d = S_DONE;
        else if (tmo) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      src_q    <= 1'b0;
      op_q     <= 1'b0;
      streak_q <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        src_q <= snp_win;
        op_q  <= snp_win ? snp_req_op[0] : cpu_req_op[0];
        // A snoop win only counts against the CPU if the CPU was asking.
        if (snp_win && cpu_req_valid) begin
          if (streak_q != STREAK_MAX) streak_q <= streak_q + SW'(1);
        end else begin
          streak_q <= '0;
        end
      end
      if (state_q == S_ISSUE) begin
        tcnt_q <= '0;
      end else if (state_q == S_WAIT && !cmpl && !tmo) begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  // Pulses and readies are held off while reset is asserted so a
  // transaction being discarded never produces a handshake or response.
  assign cpu_req_ready    = grant && cpu_win;
  assign snp_req_ready    = grant && snp_win;
  assign cpu_resp_valid   = !reset && (state_q == S_DONE) && !src_q;
  assign snp_resp_valid   = !reset && (state_q == S_DONE) && src_q;
  assign timeout_err      = !reset && tmo;
  assign ctrl_cpu_request = in_flight ? {1'b0, op_q} : 2'b11;
  assign ctrl_snoop_sel   = in_flight && src_q;
  assign ctrl_start       = (state_q == S_ISSUE);
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_access_arbiter.sv
`timescale 1ns/1ps
// Testbench for cache_access_arbiter: transaction-level reference model
// compared against every output each cycle, plus directed scenarios with
// hand-computed expectations and a randomized soak.
module tb_cache_access_arbiter;

  localparam int SL = 4;
  localparam int TO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cpu_req_valid, snp_req_valid;
  logic [1:0] cpu_req_op, snp_req_op;
  logic       cpu_req_ready, snp_req_ready, cpu_resp_valid, snp_resp_valid;
  logic [1:0] ctrl_cpu_request;
  logic       ctrl_snoop_sel, ctrl_start, cache_ready, cache_complete;
  logic       busy, timeout_err;

  cache_access_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_op(cpu_req_op),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .snp_req_valid(snp_req_valid), .snp_req_op(snp_req_op),
    .snp_req_ready(snp_req_ready), .snp_resp_valid(snp_resp_valid),
    .ctrl_cpu_request(ctrl_cpu_request), .ctrl_snoop_sel(ctrl_snoop_sel),
    .ctrl_start(ctrl_start), .cache_ready(cache_ready),
    .cache_complete(cache_complete), .busy(busy), .timeout_err(timeout_err)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a transaction is described by its age (cycles since
  // acceptance) plus whether completion has been seen.
  bit m_busy   = 0;
  bit m_finish = 0;   // completion seen, response pending this cycle
  bit m_src    = 0;   // 1 = snoop owns the transaction
  bit m_op     = 0;
  int m_age    = 0;   // 1 = issue cycle, >=2 = waiting (wait index age-2)
  int m_streak = 0;
  bit m_gcpu, m_gsnp;

  // Snapshot of DUT outputs taken mid-cycle by cycle().
  logic       s_cpu_ready, s_snp_ready, s_cpu_resp, s_snp_resp;
  logic       s_start, s_sel, s_busy, s_terr;
  logic [1:0] s_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, compare against the model, advance the
  // model to what the coming posedge must do, return just after posedge.
  task automatic cycle();
    logic [9:0] e, a;
    bit cwin, swin;
    @(negedge clk);
    s_cpu_ready = cpu_req_ready;  s_snp_ready = snp_req_ready;
    s_cpu_resp  = cpu_resp_valid; s_snp_resp  = snp_resp_valid;
    s_start = ctrl_start; s_sel = ctrl_snoop_sel; s_busy = busy;
    s_terr = timeout_err; s_req = ctrl_cpu_request;
    // bundle: cpu_rdy snp_rdy cpu_resp snp_resp start sel busy terr req[1:0]
    a = {s_cpu_ready, s_snp_ready, s_cpu_resp, s_snp_resp,
         s_start, s_sel, s_busy, s_terr, s_req};
    cwin = 0; swin = 0;
    if (!m_busy) begin
      cwin = cpu_req_valid && (!snp_req_valid || m_streak == SL);
      swin = snp_req_valid && !cwin;
      e = {cwin, swin, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11};
    end else if (m_finish) begin
      e = {1'b0, 1'b0, !m_src, m_src, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11};
    end else if (m_age == 1) begin
      e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_src, 1'b1, 1'b0, 1'b0, m_op};
    end else begin
      e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_src, 1'b1,
           !(cache_complete && cache_ready) && (m_age - 2 == TO - 1), 1'b0, m_op};
    end
    if (!reset) begin
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs cycle %0d: got %b expected %b", cyc, a, e);
      end
    end
    m_gcpu = !reset && cwin;
    m_gsnp = !reset && swin;
    if (reset) begin
      m_busy = 0; m_finish = 0; m_streak = 0;
    end else if (!m_busy) begin
      if (cwin || swin) begin
        m_busy = 1; m_finish = 0; m_age = 1; m_src = swin;
        m_op = swin ? snp_req_op[0] : cpu_req_op[0];
        if (swin && cpu_req_valid) m_streak = (m_streak < SL) ? m_streak + 1 : SL;
        else m_streak = 0;
      end
    end else if (m_finish) begin
      m_busy = 0; m_finish = 0;
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (cache_complete && cache_ready) begin
      m_finish = 1;
    end else if (m_age - 2 == TO - 1) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Issue cycle, one wait cycle with completion, response cycle.
  task automatic finish_txn();
    cache_complete = 0; cycle();
    cache_complete = 1; cycle();
    cache_complete = 0; cycle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] order;
    int n_terr, at_terr, n_resp;
    logic busy_after;
    reset = 1; cpu_req_valid = 0; snp_req_valid = 0;
    cpu_req_op = 0; snp_req_op = 0; cache_ready = 1; cache_complete = 0;
    cycle(); cycle();
    reset = 0;

    // Reset values.
    cycle();
    check("rst_busy", s_busy, 0);
    check("rst_req", s_req, 2'b11);
    check("rst_misc", {s_cpu_ready, s_snp_ready, s_cpu_resp, s_snp_resp, s_start, s_sel, s_terr}, 0);

    // CPU-only read, completion 3 cycles after issue.
    cpu_req_valid = 1; cpu_req_op = 2'b00;
    cycle(); check("cpu_rd_ready", s_cpu_ready, 1);
    cpu_req_valid = 0;
    cycle(); check("cpu_rd_issue", {s_start, s_sel, s_req}, 4'b1_0_00);
    cycle(); cycle();
    cache_complete = 1; cycle(); check("cpu_rd_noresp_yet", s_cpu_resp, 0);
    cache_complete = 0;
    cycle(); check("cpu_rd_resp", {s_cpu_resp, s_req}, 3'b1_11);
    cycle(); check("cpu_rd_idle", s_busy, 0);

    // Simultaneous requests with streak 0: snoop wins, CPU next.
    cpu_req_valid = 1; cpu_req_op = 2'b00; snp_req_valid = 1; snp_req_op = 2'b01;
    cycle(); check("sim_ready", {s_cpu_ready, s_snp_ready}, 2'b01);
    snp_req_valid = 0;
    cycle(); check("sim_issue", {s_sel, s_req}, 3'b1_01);
    cache_complete = 1; cycle();
    cache_complete = 0; cycle(); check("sim_snp_resp", {s_snp_resp, s_cpu_resp}, 2'b10);
    cycle(); check("sim_cpu_next", s_cpu_ready, 1);
    cpu_req_valid = 0;
    finish_txn();

    // Starvation: both ports continuously valid.
    cpu_req_valid = 1; snp_req_valid = 1; cpu_req_op = 2'b01; snp_req_op = 2'b00;
    order = '0;
    for (int g = 0; g < 10; g++) begin
      cycle();
      check("starve_onehot", s_cpu_ready + s_snp_ready, 1);
      order[g] = s_cpu_ready;
      finish_txn();
    end
    check("starve_order", order, 10'b10_0001_0000);
    cpu_req_valid = 0; snp_req_valid = 0;
    cycle();

    // Timeout: completion never arrives.
    cpu_req_valid = 1; cpu_req_op = 2'b01; cache_complete = 0;
    cycle(); check("to_accept", s_cpu_ready, 1);
    cpu_req_valid = 0;
    n_terr = 0; at_terr = -1; n_resp = 0; busy_after = 1'bx;
    for (int i = 1; i <= 70; i++) begin
      cycle();
      if (s_terr) begin n_terr++; at_terr = i; end
      if (s_cpu_resp || s_snp_resp) n_resp++;
      if (at_terr >= 0 && i == at_terr + 1) busy_after = s_busy;
    end
    check("to_count", n_terr, 1);
    check("to_cycle", at_terr, 65);
    check("to_noresp", n_resp, 0);
    check("to_busy_after", busy_after, 0);
    cpu_req_valid = 1;
    cycle(); check("to_next_accept", s_cpu_ready, 1);
    cpu_req_valid = 0;
    finish_txn();

    // Reset during WAIT, then a late completion.
    snp_req_valid = 1; snp_req_op = 2'b00;
    cycle(); snp_req_valid = 0;
    cycle(); cycle();
    reset = 1; cycle();
    reset = 0; cache_complete = 1;
    cycle();
    check("rmid_state", {s_busy, s_req, s_start, s_sel}, 5'b0_11_0_0);
    check("rmid_pulses", {s_cpu_resp, s_snp_resp, s_terr, s_cpu_ready, s_snp_ready}, 0);
    cache_complete = 0;
    cycle(); check("rmid_no_late_resp", {s_cpu_resp, s_snp_resp}, 0);

    // Op folding: 11 is issued as 01.
    cpu_req_valid = 1; cpu_req_op = 2'b11;
    cycle(); cpu_req_valid = 0;
    cycle(); check("fold_issue", {s_start, s_req}, 3'b1_01);
    cycle(); check("fold_wait", s_req, 2'b01);
    cache_complete = 1; cycle();
    cache_complete = 0; cycle(); cycle();

    // Randomized soak; stall windows force timeouts.
    for (int k = 0; k < 4000; k++) begin
      if (!cpu_req_valid) begin
        cpu_req_valid = ($urandom_range(0, 2) == 0);
        cpu_req_op = 2'($urandom_range(0, 3));
      end
      if (!snp_req_valid) begin
        snp_req_valid = ($urandom_range(0, 1) == 0);
        snp_req_op = 2'($urandom_range(0, 3));
      end
      cache_ready    = ($urandom_range(0, 7) != 0);
      cache_complete = ((k % 700) < 100) ? 1'b0 : ($urandom_range(0, 3) == 0);
      reset          = ($urandom_range(0, 299) == 0);
      cycle();
      if (m_gcpu) cpu_req_valid = 0;
      if (m_gsnp) snp_req_valid = 0;
    end
    reset = 0; cpu_req_valid = 0; snp_req_valid = 0; cache_complete = 0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_access_arbiter.md
Name: cache_access_arbiter

Overview:
- Sits in front of cache_controller and shares its single request interface between the CPU request port and the interconnect snoop port.
- Arbitrates between the two ports and latches the winning operation.
- Sequences one transaction at a time: accept, issue, wait for completion, respond.
- Bounds CPU starvation and flags transactions that never complete.

Parameters:
STARVE_LIMIT, 4, max consecutive snoop grants while CPU is waiting before CPU is forced to win (>=1)
TIMEOUT, 64, max cycles in WAIT for cache_complete before abort (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
cpu_req_valid  input  1  CPU request pending
cpu_req_op  input  2  CPU op: 00 read, 01 write
cpu_req_ready  output  1  CPU request accepted this cycle
cpu_resp_valid  output  1  one-cycle pulse: CPU transaction finished
snp_req_valid  input  1  snoop request pending
snp_req_op  input  2  snoop op: 00 read-shared, 01 invalidate
snp_req_ready  output  1  snoop request accepted this cycle
snp_resp_valid  output  1  one-cycle pulse: snoop transaction finished
ctrl_cpu_request  output  2  op driven to cache_controller; 11 = no request
ctrl_snoop_sel  output  1  1 = current op originates from snoop port
ctrl_start  output  1  one-cycle issue strobe to controller
cache_ready  input  1  from cache_controller
cache_complete  input  1  from cache_controller
busy  output  1  arbiter not in IDLE
timeout_err  output  1  one-cycle pulse on WAIT timeout

Behaviour:
- Reset values: state IDLE; ctrl_cpu_request=11; all other outputs 0; streak counter 0; timeout counter 0.
- Reset asserted mid-transaction: return to IDLE next edge, no resp pulse, no timeout_err, latched op discarded.
- States:
  - IDLE: if any valid, arbitrate combinationally; assert the winner's *_req_ready in the same cycle; latch op and source; go to ISSUE. The loser's ready stays 0 and its valid is held by the requester.
  - ISSUE: exactly 1 cycle. ctrl_start=1, ctrl_cpu_request=latched op, ctrl_snoop_sel=source. Go to WAIT and clear the timeout counter.
  - WAIT: hold ctrl_cpu_request/ctrl_snoop_sel with ctrl_start=0.
    - cache_complete && cache_ready sampled high: go to DONE.
    - Otherwise the timeout counter increments; on reaching TIMEOUT-1, pulse timeout_err and go to IDLE with no resp pulse.
    - cache_complete is ignored during ISSUE.
  - DONE: 1 cycle. Pulse the owner's *_resp_valid; ctrl_cpu_request=11; go to IDLE.
- busy=1 in ISSUE/WAIT/DONE. *_req_ready is never asserted outside IDLE.
- Minimum transaction: 4 cycles (accept, issue, WAIT with complete, DONE). Back-to-back accept is possible the cycle after DONE.
- Arbitration:
  - Snoop has priority.
  - Exception: if cpu_req_valid && streak==STARVE_LIMIT, CPU wins.
  - Only one valid: that port wins.
- Streak counter, width $clog2(STARVE_LIMIT+1):
  - Increments (saturating at STARVE_LIMIT) on each snoop grant made while cpu_req_valid=1.
  - Cleared on CPU grant, or on a snoop grant made while cpu_req_valid=0.
- Ops: only op[1] ignored; op values 10/11 are treated as 00/01 respectively (bit 0 selects read/write). ctrl_cpu_request is never 10/11 except the idle 11.
- Timeout counter width $clog2(TIMEOUT); it never wraps because it exits at TIMEOUT-1.

Test Plan:
- CPU-only read: cpu_req_valid=1, op=00; cache_complete&cache_ready 3 cycles after ISSUE -> cpu_req_ready at cycle 0, ctrl_start at cycle 1 with ctrl_cpu_request=00, ctrl_snoop_sel=0, cpu_resp_valid one cycle after complete is sampled, then ctrl_cpu_request=11.
- Simultaneous valid, streak=0: both valid, snp op=01 -> snp_req_ready=1, cpu_req_ready=0; ctrl_snoop_sel=1, ctrl_cpu_request=01; CPU is granted at the next IDLE if snoop valid drops.
- Starvation, STARVE_LIMIT=4: CPU and snoop continuously valid -> grant order S,S,S,S,C,S,S,S,S,C; streak returns to 0 after each C.
- Timeout, TIMEOUT=64: cache_complete held 0 after ISSUE -> timeout_err pulses exactly once, 63 cycles into WAIT; no resp pulse; busy=0 next cycle; the next request is accepted.
- Reset mid-WAIT: reset high for 1 cycle during WAIT -> next cycle all outputs at reset values and ctrl_cpu_request=11; a late cache_complete produces no resp pulse.
- Op folding: cpu_req_op=11 -> ctrl_cpu_request=01 during ISSUE/WAIT.
